// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search core.
//   state_e       : one-hot top-level FSM states
//   phase_e       : sub-step within SWAP / DECRYPT
//   S_DEPTH       : depth of the RC4 state array
//   CHAR_*        : accepted plaintext bytes ('a'..'z' and space)
//   is_valid_char : plaintext acceptance test
package rc4_pkg;

  localparam int unsigned S_DEPTH = 256;

  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    INIT     = 6'b000010,
    SWAP     = 6'b000100,
    DECRYPT  = 6'b001000,
    NEXT_KEY = 6'b010000,
    DONE     = 6'b100000
  } state_e;

  typedef enum logic [2:0] {
    PH_RD_I,    // read S[i]
    PH_SWAP_J,  // write S[j] <= S[i], old S[j] returned next cycle
    PH_WR_I,    // write S[i] <= old S[j]
    PH_RD_T,    // read S[S[i]+S[j]]
    PH_CHECK,   // keystream byte available: decrypt and validate
    PH_FIN      // last byte written, report success
  } phase_e;

  function automatic logic is_valid_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/key_search_core_s_memory.sv
// 256x8 single-port RAM holding the RC4 S array.
// Synchronous read with one cycle of latency. A write cycle also returns
// the word that was stored at addr_i before the write (read-old-data).
//   clk_i   : clock
//   addr_i  : word address
//   wdata_i : write data
//   wren_i  : write enable
//   rdata_o : registered read data
module s_memory
  import rc4_pkg::*;
(
  input  logic       clk_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic       wren_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [S_DEPTH];

  always_ff @(posedge clk_i) begin
    if (wren_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/key_search_core.sv
// RC4 brute-force key search core.
// Tries keys starting at key_start_value, stepping by KEY_STRIDE up to
// KEY_LIMIT, decrypting an external ciphertext ROM into an external RAM and
// accepting a key when every plaintext byte is 'a'..'z' or space.
//
// Ports
//   clk, reset (sync, active high)
//   datapath_start_flag : level request to search
//   stop                : abort to DONE with no result
//   key_start_value     : first key tried
//   enc_addr / enc_data : ciphertext ROM, data valid one cycle after address
//   dec_addr / dec_data / dec_wren : plaintext RAM write port
//   secret_key          : key under trial; the winner once found
//   key_found_flag / key_fail_flag / datapath_done_flag : result status
//
// Cycles per key: INIT 256 + SWAP 3*256 + DECRYPT (1 + 4 per byte checked)
// + 1 (NEXT_KEY or final report) -> at most 1154 for MSG_LEN=32.
module key_search_core
  import rc4_pkg::*;
#(
  parameter int unsigned            KEY_BYTES  = 3,
  parameter int unsigned            MSG_LEN    = 32,
  parameter int unsigned            KEY_STRIDE = 1,
  parameter logic [8*KEY_BYTES-1:0] KEY_LIMIT  = 24'h3FFFFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         datapath_start_flag,
  input  logic                         stop,
  input  logic [8*KEY_BYTES-1:0]       key_start_value,
  output logic [$clog2(MSG_LEN)-1:0]   enc_addr,
  input  logic [7:0]                   enc_data,
  output logic [$clog2(MSG_LEN)-1:0]   dec_addr,
  output logic [7:0]                   dec_data,
  output logic                         dec_wren,
  output logic [8*KEY_BYTES-1:0]       secret_key,
  output logic                         key_found_flag,
  output logic                         key_fail_flag,
  output logic                         datapath_done_flag
);

  localparam int unsigned     KEY_W      = 8 * KEY_BYTES;
  localparam int unsigned     AW         = $clog2(MSG_LEN);
  localparam logic [AW-1:0]   LAST_K     = AW'(MSG_LEN - 1);
  localparam logic [7:0]      LAST_KB    = 8'(KEY_BYTES - 1);
  localparam logic [KEY_W:0]  STRIDE_EXT = (KEY_W + 1)'(KEY_STRIDE);

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [7:0]       i_q, i_d;
  logic [7:0]       j_q, j_d;
  logic [7:0]       kidx_q, kidx_d;
  logic [AW-1:0]    k_q, k_d;
  logic [7:0]       si_q, si_d;
  logic [7:0]       sj_q, sj_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             found_q, found_d;
  logic             fail_q, fail_d;
  logic [AW-1:0]    enc_addr_q, enc_addr_d;
  logic [AW-1:0]    dec_addr_q, dec_addr_d;
  logic [7:0]       dec_data_q, dec_data_d;
  logic             dec_wren_q, dec_wren_d;

  logic [7:0]       mem_addr, mem_wdata, mem_rdata;
  logic             mem_we;
  logic [7:0]       key_byte, j_step, plain;
  logic [KEY_W:0]   key_sum;
  logic             key_exhausted;

  s_memory u_s_mem (
    .clk_i   (clk),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .wren_i  (mem_we),
    .rdata_o (mem_rdata)
  );

  // Key byte 0 is the most significant byte of the key.
  always_comb begin
    key_byte = '0;
    for (int unsigned b = 0; b < KEY_BYTES; b++) begin
      if (kidx_q == 8'(b)) begin
        key_byte = key_q[KEY_W-8-8*b +: 8];
      end
    end
  end

  assign j_step        = j_q + mem_rdata + ((state_q == SWAP) ? key_byte : 8'h00);
  assign plain         = mem_rdata ^ enc_data;
  assign key_sum       = {1'b0, key_q} + STRIDE_EXT;
  assign key_exhausted = key_sum[KEY_W] || (key_sum[KEY_W-1:0] > KEY_LIMIT);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    i_d        = i_q;
    j_d        = j_q;
    kidx_d     = kidx_q;
    k_d        = k_q;
    si_d       = si_q;
    sj_d       = sj_q;
    key_d      = key_q;
    found_d    = found_q;
    fail_d     = fail_q;
    enc_addr_d = enc_addr_q;
    dec_addr_d = dec_addr_q;
    dec_data_d = dec_data_q;
    dec_wren_d = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (datapath_start_flag) begin
          key_d   = key_start_value;
          found_d = 1'b0;
          fail_d  = 1'b0;
          i_d     = '0;
          state_d = INIT;
        end
      end

      INIT: begin
        mem_addr  = i_q;
        mem_wdata = i_q;
        mem_we    = 1'b1;
        i_d       = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          j_d     = '0;
          kidx_d  = '0;
          phase_d = PH_RD_I;
          state_d = SWAP;
        end
      end

      // The S[j] write doubles as the S[j] read (old data returned),
      // so each swap costs three RAM cycles instead of four.
      SWAP: begin
        case (phase_q)
          PH_RD_I: begin
            mem_addr = i_q;
            phase_d  = PH_SWAP_J;
          end
          PH_SWAP_J: begin
            mem_addr  = j_step;
            mem_wdata = mem_rdata;
            mem_we    = 1'b1;
            j_d       = j_step;
            phase_d   = PH_WR_I;
          end
          PH_WR_I: begin
            mem_addr  = i_q;
            mem_wdata = mem_rdata;
            mem_we    = 1'b1;
            i_d       = i_q + 8'd1;
            kidx_d    = (kidx_q == LAST_KB) ? 8'h00 : kidx_q + 8'd1;
            phase_d   = PH_RD_I;
            if (i_q == 8'hFF) begin
              j_d        = '0;
              k_d        = '0;
              enc_addr_d = '0;
              state_d    = DECRYPT;
            end
          end
          default: phase_d = PH_RD_I;
        endcase
      end

      // The check of byte k overlaps the S[i+1] read for byte k+1.
      DECRYPT: begin
        case (phase_q)
          PH_RD_I: begin
            mem_addr = i_q + 8'd1;
            i_d      = i_q + 8'd1;
            phase_d  = PH_SWAP_J;
          end
          PH_SWAP_J: begin
            mem_addr  = j_step;
            mem_wdata = mem_rdata;
            mem_we    = 1'b1;
            si_d      = mem_rdata;
            j_d       = j_step;
            phase_d   = PH_WR_I;
          end
          PH_WR_I: begin
            mem_addr  = i_q;
            mem_wdata = mem_rdata;
            mem_we    = 1'b1;
            sj_d      = mem_rdata;
            phase_d   = PH_RD_T;
          end
          PH_RD_T: begin
            mem_addr = si_q + sj_q;
            phase_d  = PH_CHECK;
          end
          PH_CHECK: begin
            if (!is_valid_char(plain)) begin
              state_d = NEXT_KEY;
            end else begin
              dec_addr_d = k_q;
              dec_data_d = plain;
              dec_wren_d = 1'b1;
              if (k_q == LAST_K) begin
                phase_d = PH_FIN;
              end else begin
                k_d        = k_q + AW'(1);
                enc_addr_d = k_q + AW'(1);
                mem_addr   = i_q + 8'd1;
                i_d        = i_q + 8'd1;
                phase_d    = PH_SWAP_J;
              end
            end
          end
          PH_FIN: begin
            found_d = 1'b1;
            state_d = DONE;
          end
          default: phase_d = PH_RD_I;
        endcase
      end

      NEXT_KEY: begin
        if (key_exhausted) begin
          fail_d  = 1'b1;
          state_d = DONE;
        end else begin
          key_d   = key_sum[KEY_W-1:0];
          i_d     = '0;
          state_d = INIT;
        end
      end

      DONE: begin
        if (!datapath_start_flag) begin
          found_d = 1'b0;
          fail_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (stop && (state_q != IDLE) && (state_q != DONE)) begin
      state_d    = DONE;
      found_d    = 1'b0;
      fail_d     = 1'b0;
      dec_wren_d = 1'b0;
      mem_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      phase_q    <= PH_RD_I;
      i_q        <= '0;
      j_q        <= '0;
      kidx_q     <= '0;
      k_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      key_q      <= '0;
      found_q    <= 1'b0;
      fail_q     <= 1'b0;
      enc_addr_q <= '0;
      dec_addr_q <= '0;
      dec_data_q <= '0;
      dec_wren_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      i_q        <= i_d;
      j_q        <= j_d;
      kidx_q     <= kidx_d;
      k_q        <= k_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      key_q      <= key_d;
      found_q    <= found_d;
      fail_q     <= fail_d;
      enc_addr_q <= enc_addr_d;
      dec_addr_q <= dec_addr_d;
      dec_data_q <= dec_data_d;
      dec_wren_q <= dec_wren_d;
    end
  end

  assign enc_addr           = enc_addr_q;
  assign dec_addr           = dec_addr_q;
  assign dec_data           = dec_data_q;
  assign dec_wren           = dec_wren_q;
  assign secret_key         = key_q;
  assign key_found_flag     = found_q;
  assign key_fail_flag      = fail_q;
  assign datapath_done_flag = (state_q == DONE);

endmodule

// File: tb/tb_key_search_core.sv
// Directed bench for key_search_core.
// u0: defaults (start 0), u1: stride 2 (start 1), u2: limit 2 (start 0),
// u3: limit FFFFFF, start FFFFFF, ciphertext whose first byte cannot decode.
module tb_key_search_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst0, clr0;
  logic [3:0]  start, stop, found, fail, done, wren;
  logic [23:0] kstart [4];
  logic [23:0] skey   [4];
  logic [4:0]  ea     [4];
  logic [4:0]  da     [4];
  logic [7:0]  ed     [4];
  logic [7:0]  dd     [4];

  logic [7:0]  rom_a [32];
  logic [7:0]  rom_b [32];
  logic [7:0]  ram0  [32];
  logic [7:0]  ram1  [32];
  int          wr0 = 0;
  int          wr3 = 0;

  int checks = 0;
  int errors = 0;

  key_search_core u0 (
    .clk(clk), .reset(rst0), .datapath_start_flag(start[0]), .stop(stop[0]),
    .key_start_value(kstart[0]), .enc_addr(ea[0]), .enc_data(ed[0]),
    .dec_addr(da[0]), .dec_data(dd[0]), .dec_wren(wren[0]), .secret_key(skey[0]),
    .key_found_flag(found[0]), .key_fail_flag(fail[0]), .datapath_done_flag(done[0])
  );

  key_search_core #(.KEY_STRIDE(2)) u1 (
    .clk(clk), .reset(rst), .datapath_start_flag(start[1]), .stop(stop[1]),
    .key_start_value(kstart[1]), .enc_addr(ea[1]), .enc_data(ed[1]),
    .dec_addr(da[1]), .dec_data(dd[1]), .dec_wren(wren[1]), .secret_key(skey[1]),
    .key_found_flag(found[1]), .key_fail_flag(fail[1]), .datapath_done_flag(done[1])
  );

  key_search_core #(.KEY_LIMIT(24'h000002)) u2 (
    .clk(clk), .reset(rst), .datapath_start_flag(start[2]), .stop(stop[2]),
    .key_start_value(kstart[2]), .enc_addr(ea[2]), .enc_data(ed[2]),
    .dec_addr(da[2]), .dec_data(dd[2]), .dec_wren(wren[2]), .secret_key(skey[2]),
    .key_found_flag(found[2]), .key_fail_flag(fail[2]), .datapath_done_flag(done[2])
  );

  key_search_core #(.KEY_LIMIT(24'hFFFFFF)) u3 (
    .clk(clk), .reset(rst), .datapath_start_flag(start[3]), .stop(stop[3]),
    .key_start_value(kstart[3]), .enc_addr(ea[3]), .enc_data(ed[3]),
    .dec_addr(da[3]), .dec_data(dd[3]), .dec_wren(wren[3]), .secret_key(skey[3]),
    .key_found_flag(found[3]), .key_fail_flag(fail[3]), .datapath_done_flag(done[3])
  );

  // Registered ROM reads: data one cycle after the address.
  always @(posedge clk) begin
    ed[0] <= rom_a[ea[0]];
    ed[1] <= rom_a[ea[1]];
    ed[2] <= rom_a[ea[2]];
    ed[3] <= rom_b[ea[3]];
  end

  always @(posedge clk) begin
    if (clr0) begin
      for (int n = 0; n < 32; n++) ram0[n] <= 8'h00;
    end else if (wren[0]) begin
      ram0[da[0]] <= dd[0];
    end
    if (wren[0]) wr0 <= wr0 + 1;
    if (wren[1]) ram1[da[1]] <= dd[1];
    if (wren[3]) wr3 <= wr3 + 1;
  end

  function automatic logic [7:0] pt_byte(input int k);
    return 8'h61 + 8'(k % 26);
  endfunction

  // Reference RC4: which=0 -> rom_a = plaintext ^ ks, which=1 -> rom_b = ks.
  task automatic rc4_fill(input logic [23:0] key, input int which);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] t, ks;
    int unsigned i, j;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + int'(s[n]) + int'(kb[n % 3])) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int k = 0; k < 32; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(s[i])) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks = s[(int'(s[i]) + int'(s[j])) % 256];
      if (which == 0) rom_a[k] = pt_byte(k) ^ ks;
      else            rom_b[k] = ks;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int idx, input int limit, input string tag, output int cyc);
    cyc = 0;
    while (!done[idx] && cyc < limit) begin
      tick();
      cyc++;
    end
    chk(tag, 32'(done[idx]), 32'd1);
  endtask

  function automatic int ram0_mism();
    int m = 0;
    for (int k = 0; k < 32; k++) if (ram0[k] !== pt_byte(k)) m++;
    return m;
  endfunction

  function automatic int ram1_mism();
    int m = 0;
    for (int k = 0; k < 32; k++) if (ram1[k] !== pt_byte(k)) m++;
    return m;
  endfunction

  task automatic chk_zero_u0(input string tag);
    chk({tag, "_key"},   32'(skey[0]),  32'd0);
    chk({tag, "_found"}, 32'(found[0]), 32'd0);
    chk({tag, "_fail"},  32'(fail[0]),  32'd0);
    chk({tag, "_done"},  32'(done[0]),  32'd0);
    chk({tag, "_wren"},  32'(wren[0]),  32'd0);
    chk({tag, "_eaddr"}, 32'(ea[0]),    32'd0);
    chk({tag, "_daddr"}, 32'(da[0]),    32'd0);
    chk({tag, "_ddata"}, 32'(dd[0]),    32'd0);
  endtask

  initial begin
    int cyc;
    int n;
    int wr_before;

    rst   = 1'b1;
    rst0  = 1'b1;
    clr0  = 1'b0;
    start = '0;
    stop  = '0;
    for (int u = 0; u < 4; u++) kstart[u] = '0;
    rc4_fill(24'h000003, 0);
    rc4_fill(24'hFFFFFF, 1);
    repeat (3) tick();
    chk_zero_u0("reset");

    // Concurrent searches on all four cores.
    rst       = 1'b0;
    rst0      = 1'b0;
    kstart[0] = 24'h000000;
    kstart[1] = 24'h000001;
    kstart[2] = 24'h000000;
    kstart[3] = 24'hFFFFFF;
    start     = 4'hF;
    wait_done(0, 6000, "u0_done_timeout", cyc);
    chk("u0_cycle_bound", 32'(cyc <= 4642), 32'd1);
    chk("u0_found", 32'(found[0]), 32'd1);
    chk("u0_fail",  32'(fail[0]),  32'd0);
    chk("u0_key",   32'(skey[0]),  32'h000003);
    chk("u0_ram_mismatches", 32'(ram0_mism()), 32'd0);
    chk("u0_ram_first", 32'(ram0[0]),  32'h61);
    chk("u0_ram_last",  32'(ram0[31]), 32'h66);

    wait_done(1, 3000, "u1_done_timeout", cyc);
    chk("u1_found", 32'(found[1]), 32'd1);
    chk("u1_fail",  32'(fail[1]),  32'd0);
    chk("u1_key",   32'(skey[1]),  32'h000003);
    chk("u1_ram_mismatches", 32'(ram1_mism()), 32'd0);

    wait_done(2, 3000, "u2_done_timeout", cyc);
    chk("u2_fail",  32'(fail[2]),  32'd1);
    chk("u2_found", 32'(found[2]), 32'd0);
    chk("u2_key",   32'(skey[2]),  32'h000002);

    wait_done(3, 3000, "u3_done_timeout", cyc);
    chk("u3_fail",   32'(fail[3]),  32'd1);
    chk("u3_found",  32'(found[3]), 32'd0);
    chk("u3_key",    32'(skey[3]),  32'hFFFFFF);
    chk("u3_writes", 32'(wr3),      32'd0);

    // DONE -> IDLE on start low, then a fresh search from key_start_value.
    start[0] = 1'b0;
    tick();
    chk("idle_done",  32'(done[0]),  32'd0);
    chk("idle_found", 32'(found[0]), 32'd0);
    chk("idle_fail",  32'(fail[0]),  32'd0);
    start[0] = 1'b1;
    tick();
    chk("restart_key", 32'(skey[0]), 32'h000000);

    // Abort during SWAP of key 1.
    n = 0;
    while (skey[0] != 24'h000001 && n < 2000) begin
      tick();
      n++;
    end
    chk("reach_key1", 32'(skey[0]), 32'h000001);
    repeat (300) tick();
    wr_before = wr0;
    stop[0]   = 1'b1;
    n = 0;
    while (!done[0] && n < 2) begin
      tick();
      n++;
    end
    chk("stop_done", 32'(done[0]),  32'd1);
    chk("stop_found", 32'(found[0]), 32'd0);
    chk("stop_fail",  32'(fail[0]),  32'd0);
    repeat (10) tick();
    chk("stop_no_writes", 32'(wr0), 32'(wr_before));
    chk("stop_key_held",  32'(skey[0]), 32'h000001);
    stop[0]  = 1'b0;
    start[0] = 1'b0;
    tick();
    chk("stop_idle_done", 32'(done[0]), 32'd0);

    // Reset in the middle of decrypting with key 3, then rerun.
    start[0] = 1'b1;
    n = 0;
    while (!(skey[0] == 24'h000003 && wren[0]) && n < 6000) begin
      tick();
      n++;
    end
    chk("reach_decrypt_key3", 32'(wren[0]), 32'd1);
    rst0 = 1'b1;
    clr0 = 1'b1;
    tick();
    chk_zero_u0("midreset");
    rst0 = 1'b0;
    clr0 = 1'b0;
    wait_done(0, 6000, "rerun_done_timeout", cyc);
    chk("rerun_found", 32'(found[0]), 32'd1);
    chk("rerun_fail",  32'(fail[0]),  32'd0);
    chk("rerun_key",   32'(skey[0]),  32'h000003);
    chk("rerun_ram_mismatches", 32'(ram0_mism()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
